// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: recovers pixel x/y from VGA sync timing and renders one of four test patterns
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BAR_W    = 80,
  parameter int BOX      = 16
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_n_in,
  input  logic [1:0]  mode_sel,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [15:0] frame_cnt
);
  localparam int BW = $clog2(BAR_W);
  localparam logic [10:0] BX_MAX = 11'(H_ACTIVE - BOX);
  localparam logic [9:0] BY_MAX = 10'(V_ACTIVE - BOX);
  localparam logic [11:0] BAR_LUT [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};
  logic [10:0] x_cnt_q, x_cnt_d, box_x_q, box_x_d;
  logic [9:0] y_cnt_q, y_cnt_d, box_y_q, box_y_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  logic [1:0] mode_q, mode_d;
  logic dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic prev_blank_q, prev_vs_q;
  logic [11:0] rgb_q, rgb_d, pat_rgb;
  logic hs_q, vs_q, blank_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic vs_fall, blank_fall, bar_end, in_box, visible;
  always_comb begin
    vs_fall = prev_vs_q & ~vs_in;
    blank_fall = prev_blank_q & ~blank_n_in;
    bar_end = bar_px_q == BW'(BAR_W - 1);
    x_cnt_d = !blank_n_in ? '0 : (&x_cnt_q) ? x_cnt_q : x_cnt_q + 11'd1;
    bar_px_d = (!blank_n_in || bar_end) ? '0 : bar_px_q + BW'(1);
    bar_idx_d = !blank_n_in ? '0 : (bar_end && bar_idx_q != 3'd7) ? bar_idx_q + 3'd1 : bar_idx_q;
    y_cnt_d = vs_fall ? '0 : (blank_fall && !(&y_cnt_q)) ? y_cnt_q + 10'd1 : y_cnt_q;
    mode_d = vs_fall ? mode_sel : mode_q;
    frame_cnt_d = frame_cnt_q + 16'(vs_fall);
    // a bounce flips direction and moves one step the new way in the same frame
    dx_neg_d = (vs_fall && (dx_neg_q ? box_x_q == '0 : box_x_q == BX_MAX)) ? ~dx_neg_q : dx_neg_q;
    dy_neg_d = (vs_fall && (dy_neg_q ? box_y_q == '0 : box_y_q == BY_MAX)) ? ~dy_neg_q : dy_neg_q;
    box_x_d = !vs_fall ? box_x_q : dx_neg_d ? box_x_q - 11'd1 : box_x_q + 11'd1;
    box_y_d = !vs_fall ? box_y_q : dy_neg_d ? box_y_q - 10'd1 : box_y_q + 10'd1;
    in_box = x_cnt_q >= box_x_q && x_cnt_q < box_x_q + 11'(BOX) &&
             y_cnt_q >= box_y_q && y_cnt_q < box_y_q + 10'(BOX);
    pat_rgb = mode_q == 2'd0 ? BAR_LUT[bar_idx_q] :
              mode_q == 2'd1 ? {12{x_cnt_q[5] ^ y_cnt_q[5]}} :
              mode_q == 2'd2 ? {3{x_cnt_q[9:6]}} :
              in_box ? 12'hFFF : 12'h008;
    visible = blank_n_in && x_cnt_q < 11'(H_ACTIVE) && y_cnt_q < 10'(V_ACTIVE);
    rgb_d = visible ? pat_rgb : '0;
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      bar_px_q <= '0;
      bar_idx_q <= '0;
      mode_q <= '0;
      box_x_q <= '0;
      box_y_q <= '0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      prev_blank_q <= 1'b0;
      prev_vs_q <= 1'b1;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      blank_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      bar_px_q <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      mode_q <= mode_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      prev_blank_q <= blank_n_in;
      prev_vs_q <= vs_in;
      rgb_q <= rgb_d;
      hs_q <= hs_in;
      vs_q <= vs_in;
      blank_q <= blank_n_in;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_blank_n = blank_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench; generator knows true pixel coordinates, model derives colour from them
module tb_vga_pattern_gen;
  localparam int BOX = 16;
  typedef struct packed {
    logic [11:0] rgb;
    logic hs, vs, bl;
    logic [15:0] fc;
  } exp_t;
  logic clk = 1'b0;
  logic reset, hs_in, vs_in, blank_n_in;
  logic [1:0] mode_sel;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank_n;
  logic [15:0] frame_cnt;
  exp_t sb[$];
  exp_t mon_e, act;
  int checks = 0, errors = 0;
  int nf_m = 0, chg_y = -1;
  logic [1:0] mode_m = 2'd0, cur_mode = 2'd0, chg_m = 2'd0;
  logic [15:0] fc_m = 16'd0;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  vga_pattern_gen dut (
    .vga_clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
    .mode_sel(mode_sel), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // box position after n frame starts: triangle wave bouncing between 0 and r
  function automatic int tri_pos(input int n, input int r);
    int p;
    p = n % (2 * r);
    return p <= r ? p : 2 * r - p;
  endfunction

  function automatic logic [11:0] model_rgb(input logic [1:0] m, input int x, input int y, input int n);
    int bx, by;
    logic [3:0] g;
    if (x >= 640 || y >= 480) return 12'h000;
    bx = tri_pos(n, 640 - BOX);
    by = tri_pos(n, 480 - BOX);
    g = 4'((x / 64) % 16);
    case (m)
      2'd0: return bars[(x / 80) > 7 ? 7 : x / 80];
      2'd1: return (((x / 32) + (y / 32)) % 2) == 1 ? 12'hFFF : 12'h000;
      2'd2: return {g, g, g};
      default: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 12'hFFF : 12'h008;
    endcase
  endfunction

  task automatic drive(input logic h, input logic v, input logic b, input int x, input int y, input bit st);
    exp_t e;
    hs_in = h;
    vs_in = v;
    blank_n_in = b;
    mode_sel = cur_mode;
    e.rgb = b ? model_rgb(mode_m, x, y, nf_m) : 12'h000;
    if (st) begin
      nf_m++;
      fc_m++;
      mode_m = cur_mode;
    end
    e.hs = h;
    e.vs = v;
    e.bl = b;
    e.fc = fc_m;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic rst(input int n, input logic b);
    exp_t e;
    reset = 1'b1;
    blank_n_in = b;
    hs_in = 1'b0;
    vs_in = 1'b0;
    e.rgb = 12'h000;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.bl = 1'b0;
    e.fc = 16'h0000;
    repeat (n) begin
      @(posedge clk);
      sb.push_back(e);
      #1;
    end
    reset = 1'b0;
    mode_m = 2'd0;
    nf_m = 0;
    fc_m = 16'h0000;
  endtask

  // one frame: VS pulse, then nl lines; line 0 and lines lo..hi are ww pixels wide, others 1 pixel
  task automatic frame(input int nl, input int lo, input int hi, input int ww);
    int w;
    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0, 1'b1);
    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int y = 0; y < nl; y++) begin
      w = (y == 0 || (y >= lo && y <= hi)) ? ww : 1;
      if (y == chg_y) cur_mode = chg_m;
      for (int x = 0; x < w; x++) drive(1'b1, 1'b1, 1'b1, x, y, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      act = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_cnt};
      checks++;
      if (act !== mon_e) begin
        errors++;
        if (errors <= 30)
          $display("FAIL out @%0t: rgb=%h hs=%b vs=%b bl=%b fc=%h, expected rgb=%h hs=%b vs=%b bl=%b fc=%h",
                   $time, act.rgb, act.hs, act.vs, act.bl, act.fc,
                   mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.bl, mon_e.fc);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, lo, k, by;
    mode_sel = 2'd0;
    rst(2, 1'b0);
    for (int x = 0; x < 10; x++) drive(1'b1, 1'b1, 1'b1, x, 0, 1'b0);
    rst(3, 1'b1);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    cur_mode = 2'd0;
    frame(2, 0, 1, 640);
    cur_mode = 2'd1;
    frame(34, 31, 33, 64);
    cur_mode = 2'd0;
    chg_y = 2;
    chg_m = 2'd1;
    frame(34, 30, 33, 100);
    chg_y = -1;
    frame(34, 31, 33, 100);
    cur_mode = 2'd2;
    frame(1, 0, 0, 640);
    cur_mode = 2'd3;
    frame(500, 478, 481, 700);
    repeat (4) begin
      cur_mode = 2'($urandom_range(0, 3));
      nl = $urandom_range(1, 60);
      lo = $urandom_range(0, nl);
      frame(nl, lo, lo + $urandom_range(0, 3), $urandom_range(1, 700));
    end
    cur_mode = 2'd3;
    while (nf_m < 630) begin
      k = nf_m + 1;
      if (k == 464 || k == 465 || k == 624 || k == 625) begin
        by = tri_pos(k, 480 - BOX);
        frame(by + BOX + 1, by - 1, by + BOX, 640);
      end else begin
        frame(0, 0, 0, 0);
      end
    end
    @(negedge clk);
    #1;
    force dut.frame_cnt_q = 16'hFFFE;
    fc_m = 16'hFFFE;
    drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    release dut.frame_cnt_q;
    frame(0, 0, 0, 0);
    frame(0, 0, 0, 0);
    cur_mode = 2'd0;
    frame(1, 0, 0, 200);
    drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
